// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle main controller and the shared datapath.
// Latency: none (wires only).
// Backpressure: none here; memory stalls are carried by mem_ready.
//
// Ports (signals):
//   opcode, mem_ready                   - datapath/memory -> controller
//   pc_write .. mem_timeout, state      - controller -> datapath (enables, muxes, ALU config, status)
// Modports: master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] branch_type;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_type, pc_src, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op,
               illegal_op, mem_timeout, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_type, pc_src, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op,
               illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller of the multicycle CPU: sequences fetch/decode/execute/memory/writeback.
// Latency: 3..5 cycles per instruction with zero-wait memory; write strobes are Mealy (same cycle).
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ready, aborting to FETCH after WAIT_TIMEOUT idle cycles.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high; forces every control output low while asserted
//   bus         - master side of multicycle_ctrl_fsm_if (opcode/mem_ready in, all controls out)
module multicycle_ctrl_fsm #(
    parameter int WAIT_TIMEOUT = 15,   // legal 1..255
    parameter int CNT_W        = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_ctrl_fsm_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_opcode;     // opcode captured on DECODE exit
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_wait_state;
    logic             w_timeout;

    // Only the three memory-facing states count idle cycles.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // mem_ready takes priority: a ready in the limit cycle is a normal completion.
    assign w_timeout    = w_wait_state && !bus.mem_ready && (r_wait_cnt == TIMEOUT_CNT);

    assign bus.state = r_state;

    // ------------------------------------------------------------------
    // Next-state and output decode. Datapath mux/ALU settings are Moore
    // (state only); ir_write/pc_write in FETCH, illegal_op and mem_timeout
    // depend on live inputs so they take effect in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next            = r_state;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_type   = 2'b00;
        bus.pc_src        = 2'b00;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.ext_op        = 1'b0;
        bus.alu_op        = 3'b000;
        bus.illegal_op    = 1'b0;
        bus.mem_timeout   = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 computed by the ALU while the instruction is read.
                bus.mem_read  = 1'b1;
                bus.iord      = 1'b0;
                bus.alu_src_a = 1'b0;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 3'b000;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    w_next       = S_DECODE;
                end else if (w_timeout) begin
                    // PC was not advanced, so re-entering FETCH retries the same address.
                    bus.mem_timeout = 1'b1;
                    w_next          = S_FETCH;
                end
            end

            S_DECODE: begin
                // Branch target precompute: PC + (sign-extended imm << 2).
                bus.alu_src_a = 1'b0;
                bus.alu_src_b = 2'b11;
                bus.alu_op    = 3'b000;
                bus.ext_op    = 1'b1;
                case (bus.opcode)
                    OP_RTYPE:               w_next = S_EXEC_R;
                    OP_LW, OP_SW:           w_next = S_MEM_ADDR;
                    OP_ADDI, OP_ORI:        w_next = S_EXEC_I;
                    OP_BEQ, OP_BNE, OP_BGTZ: w_next = S_BRANCH;
                    OP_J:                   w_next = S_JUMP;
                    default: begin
                        bus.illegal_op = 1'b1;
                        w_next         = S_FETCH;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ext_op    = 1'b1;
                bus.alu_op    = 3'b000;
                w_next        = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_timeout) begin
                    bus.mem_timeout = 1'b1;
                    w_next          = S_FETCH;
                end
            end

            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.reg_dst    = 1'b0;
                w_next         = S_FETCH;
            end

            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    bus.mem_timeout = 1'b1;
                    w_next          = S_FETCH;
                end
            end

            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b00;
                bus.alu_op    = 3'b010;
                w_next        = S_WB_R;
            end

            S_WB_R: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.mem_to_reg = 1'b0;
                w_next         = S_FETCH;
            end

            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                // ori is a logical op and wants a zero-extended immediate.
                if (r_opcode == OP_ORI) begin
                    bus.ext_op = 1'b0;
                    bus.alu_op = 3'b011;
                end else begin
                    bus.ext_op = 1'b1;
                    bus.alu_op = 3'b000;
                end
                w_next = S_WB_I;
            end

            S_WB_I: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b0;
                bus.mem_to_reg = 1'b0;
                w_next         = S_FETCH;
            end

            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_src_b     = 2'b00;
                bus.alu_op        = 3'b001;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
                case (r_opcode)
                    OP_BEQ:  bus.branch_type = 2'b01;
                    OP_BNE:  bus.branch_type = 2'b10;
                    OP_BGTZ: bus.branch_type = 2'b11;
                    default: bus.branch_type = 2'b00;
                endcase
                w_next = S_FETCH;
            end

            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
                w_next       = S_FETCH;
            end

            default: begin
                // Unused encodings recover to FETCH.
                w_next = S_FETCH;
            end
        endcase

        // Reset abandons the current instruction: nothing may write this cycle.
        if (reset) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.branch_type   = 2'b00;
            bus.pc_src        = 2'b00;
            bus.iord          = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = 2'b00;
            bus.ext_op        = 1'b0;
            bus.alu_op        = 3'b000;
            bus.illegal_op    = 1'b0;
            bus.mem_timeout   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, latched opcode and wait counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_opcode   <= 6'd0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;

            // Later states decode this copy so IR updates after DECODE are ignored.
            if (r_state == S_DECODE) begin
                r_opcode <= bus.opcode;
            end

            // A FETCH timeout does not change state, so it clears explicitly.
            if (!w_wait_state || w_timeout || (w_next != r_state)) begin
                r_wait_cnt <= '0;
            end else if (!bus.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] branch_type;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic       illegal_op;
        logic       mem_timeout;
        logic [3:0] state;
    } ctl_t;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
                           WB_MEM = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, WB_R = 4'd7,
                           EXEC_I = 4'd8, WB_I = 4'd9, BRANCH = 4'd10, JUMP = 4'd11;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_ADDI = 6'b001000, OP_ORI = 6'b001101, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_BGTZ = 6'b000111, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    ctl_t exp_q[$];
    string tag_q[$];

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm #(.WAIT_TIMEOUT(15), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected Moore outputs of each state, written from the state table.
    function automatic ctl_t base(input logic [3:0] st, input logic [5:0] lop);
        ctl_t c;
        c = '0;
        c.state = st;
        case (st)
            FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; end
            DECODE:   begin c.alu_src_b = 2'b11; c.ext_op = 1; end
            MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = 1; end
            MEM_RD:   begin c.mem_read = 1; c.iord = 1; end
            WB_MEM:   begin c.reg_write = 1; c.mem_to_reg = 1; end
            MEM_WR:   begin c.mem_write = 1; c.iord = 1; end
            EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 3'b010; end
            WB_R:     begin c.reg_write = 1; c.reg_dst = 1; end
            EXEC_I:   begin
                c.alu_src_a = 1; c.alu_src_b = 2'b10;
                if (lop == OP_ORI) begin c.ext_op = 0; c.alu_op = 3'b011; end
                else               begin c.ext_op = 1; c.alu_op = 3'b000; end
            end
            WB_I:     begin c.reg_write = 1; end
            BRANCH:   begin
                c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1; c.pc_src = 2'b01;
                c.branch_type = (lop == OP_BEQ) ? 2'b01 : (lop == OP_BNE) ? 2'b10 : 2'b11;
            end
            JUMP:     begin c.pc_write = 1; c.pc_src = 2'b10; end
            default:  ;
        endcase
        return c;
    endfunction

    function automatic ctl_t fetch_hit();
        ctl_t c;
        c = base(FETCH, OP_R);
        c.ir_write = 1;
        c.pc_write = 1;
        return c;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.branch_type   = bus.branch_type;
        c.pc_src        = bus.pc_src;
        c.iord          = bus.iord;
        c.mem_read      = bus.mem_read;
        c.mem_write     = bus.mem_write;
        c.ir_write      = bus.ir_write;
        c.reg_write     = bus.reg_write;
        c.reg_dst       = bus.reg_dst;
        c.mem_to_reg    = bus.mem_to_reg;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.ext_op        = bus.ext_op;
        c.alu_op        = bus.alu_op;
        c.illegal_op    = bus.illegal_op;
        c.mem_timeout   = bus.mem_timeout;
        c.state         = bus.state;
        return c;
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
    task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                        input ctl_t e, input string tag);
        ctl_t  obs;
        ctl_t  want;
        string t;
        reset         = rst;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs  = sample();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctl_t e;
        reset         = 1'b1;
        bus.opcode    = OP_R;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: state FETCH, every output low despite mem_ready=1.
        e = '0;
        for (int i = 0; i < 3; i++) step(1, OP_R, 1, e, "reset_hold");

        // R-type, zero-wait memory: 0,1,6,7
        step(0, OP_R, 1, fetch_hit(),          "r_fetch");
        step(0, OP_R, 1, base(DECODE, OP_R),   "r_decode");
        step(0, OP_R, 1, base(EXEC_R, OP_R),   "r_exec");
        step(0, OP_R, 1, base(WB_R, OP_R),     "r_wb");

        // lw with 3 wait cycles; IR changed to sw after DECODE must be ignored.
        step(0, OP_LW, 1, fetch_hit(),         "lw_fetch");
        step(0, OP_LW, 1, base(DECODE, OP_LW), "lw_decode");
        step(0, OP_SW, 1, base(MEM_ADDR, OP_LW), "lw_addr_latched");
        for (int i = 0; i < 3; i++) step(0, OP_SW, 0, base(MEM_RD, OP_LW), "lw_rd_wait");
        step(0, OP_SW, 1, base(MEM_RD, OP_LW), "lw_rd_ready");
        step(0, OP_SW, 1, base(WB_MEM, OP_LW), "lw_wb");

        // sw with memory never ready: 16 write cycles, timeout in the 16th.
        step(0, OP_SW, 1, fetch_hit(),         "sw_fetch");
        step(0, OP_SW, 1, base(DECODE, OP_SW), "sw_decode");
        step(0, OP_SW, 0, base(MEM_ADDR, OP_SW), "sw_addr");
        for (int i = 0; i < 15; i++) step(0, OP_SW, 0, base(MEM_WR, OP_SW), "sw_wait");
        e = base(MEM_WR, OP_SW);
        e.mem_timeout = 1;
        step(0, OP_SW, 0, e, "sw_timeout");

        // Illegal opcode: one-cycle pulse in DECODE, back to FETCH.
        step(0, OP_BAD, 1, fetch_hit(), "ill_fetch");
        e = base(DECODE, OP_BAD);
        e.illegal_op = 1;
        step(0, OP_BAD, 1, e, "ill_decode");

        // bne, with IR changed to beq during BRANCH.
        step(0, OP_BNE, 1, fetch_hit(),           "bne_fetch");
        step(0, OP_BNE, 1, base(DECODE, OP_BNE),  "bne_decode");
        step(0, OP_BEQ, 1, base(BRANCH, OP_BNE),  "bne_branch");

        // bgtz
        step(0, OP_BGTZ, 1, fetch_hit(),           "bgtz_fetch");
        step(0, OP_BGTZ, 1, base(DECODE, OP_BGTZ), "bgtz_decode");
        step(0, OP_BGTZ, 1, base(BRANCH, OP_BGTZ), "bgtz_branch");

        // addi then ori: extension and ALU op differ.
        step(0, OP_ADDI, 1, fetch_hit(),           "addi_fetch");
        step(0, OP_ADDI, 1, base(DECODE, OP_ADDI), "addi_decode");
        step(0, OP_ADDI, 1, base(EXEC_I, OP_ADDI), "addi_exec");
        step(0, OP_ADDI, 1, base(WB_I, OP_ADDI),   "addi_wb");
        step(0, OP_ORI, 1, fetch_hit(),            "ori_fetch");
        step(0, OP_ORI, 1, base(DECODE, OP_ORI),   "ori_decode");
        step(0, OP_ADDI, 1, base(EXEC_I, OP_ORI),  "ori_exec");
        step(0, OP_ADDI, 1, base(WB_I, OP_ORI),    "ori_wb");

        // jump
        step(0, OP_J, 1, fetch_hit(),          "j_fetch");
        step(0, OP_J, 1, base(DECODE, OP_J),   "j_decode");
        step(0, OP_J, 1, base(JUMP, OP_J),     "j_jump");

        // FETCH timeout retries FETCH with a cleared counter.
        for (int i = 0; i < 15; i++) step(0, OP_LW, 0, base(FETCH, OP_LW), "fetch_wait");
        e = base(FETCH, OP_LW);
        e.mem_timeout = 1;
        step(0, OP_LW, 0, e, "fetch_timeout");
        step(0, OP_LW, 0, base(FETCH, OP_LW), "fetch_cnt_cleared");
        // Counter now at 1; 14 more idle cycles brings it to the limit.
        for (int i = 0; i < 14; i++) step(0, OP_LW, 0, base(FETCH, OP_LW), "fetch_wait2");
        step(0, OP_LW, 1, fetch_hit(), "fetch_ready_wins");

        // lw, reset asserted in WB_MEM.
        step(0, OP_LW, 1, base(DECODE, OP_LW),   "lw2_decode");
        step(0, OP_LW, 1, base(MEM_ADDR, OP_LW), "lw2_addr");
        step(0, OP_LW, 1, base(MEM_RD, OP_LW),   "lw2_rd");
        e = '0;
        e.state = WB_MEM;
        step(1, OP_LW, 1, e, "reset_in_wb_mem");
        step(0, OP_R, 1, fetch_hit(), "after_reset_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
